// File: rtl/output_register_file_if.sv
// Dump stream between the output register file and the board-level result sink.
// Master drives valid/data/index, slave returns ready.
interface output_register_file_if #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 5
);
  logic              dump_valid;
  logic              dump_ready;
  logic [DATA_W-1:0] dump_data;
  logic [IDX_W-1:0]  dump_index;

  modport master (
    output dump_valid,
    output dump_data,
    output dump_index,
    input  dump_ready
  );

  modport slave (
    input  dump_valid,
    input  dump_data,
    input  dump_index,
    output dump_ready
  );
endinterface

// File: rtl/output_register_file.sv
// Result bank for OUTPUT / OUTPUT_READ with registered reads and a dump engine.
// Optional macro OUTREG_READ_CLEAR_EN: reads and dump handshakes clear occupancy.
module output_register_file #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_enable,
  input  logic              read_enable,
  input  logic [IDX_W-1:0]  output_index,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  output logic              read_miss,
  input  logic              clear_all,
  input  logic              dump_start,
  output logic              dump_busy,
  output logic              dump_done,
  output_register_file_if.master dmp
);

  localparam int DEPTH = 1 << IDX_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  occ_q, occ_d;

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic              dv_q, dv_d;
  logic [DATA_W-1:0] dd_q, dd_d;
  logic [IDX_W-1:0]  di_q, di_d;

  logic [DATA_W-1:0] rd_q, rd_d;
  logic              rv_q;
  logic              rm_q, rm_d;

  logic hs;
  logic last;
  logic scan_fwd;
  logic scan_occ;

  assign hs       = dv_q & dmp.dump_ready;
  assign last     = &ptr_q;
  assign scan_fwd = write_enable && (output_index == ptr_q);
  assign scan_occ = occ_q[ptr_q] | scan_fwd;

  // Clear first, then destructive-read clears, then the write wins its index.
  always_comb begin
    occ_d = occ_q;
    if (clear_all)
      occ_d = '0;
`ifdef OUTREG_READ_CLEAR_EN
    if (read_enable)
      occ_d[output_index] = 1'b0;
    if (hs)
      occ_d[di_q] = 1'b0;
`endif
    if (write_enable)
      occ_d[output_index] = 1'b1;
  end

  // Write-first read port.
  always_comb begin
    rd_d = rd_q;
    rm_d = 1'b0;
    if (read_enable) begin
      if (write_enable) begin
        rd_d = data_in;
      end else if (occ_q[output_index]) begin
        rd_d = mem_q[output_index];
      end else begin
        rd_d = '0;
        rm_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    dv_d    = dv_q;
    dd_d    = dd_q;
    di_d    = di_q;
    if (clear_all) begin
      state_d = S_IDLE;
      dv_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (dump_start) begin
            state_d = S_SCAN;
            ptr_d   = '0;
          end
        end
        S_SCAN: begin
          if (scan_occ) begin
            dd_d    = scan_fwd ? data_in : mem_q[ptr_q];
            di_d    = ptr_q;
            dv_d    = 1'b1;
            state_d = S_SEND;
          end else if (last) begin
            state_d = S_DONE;
          end else begin
            ptr_d = ptr_q + IDX_W'(1);
          end
        end
        S_SEND: begin
          if (hs) begin
            dv_d = 1'b0;
            if (last) begin
              state_d = S_DONE;
            end else begin
              ptr_d   = ptr_q + IDX_W'(1);
              state_d = S_SCAN;
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else if (write_enable) begin
      mem_q[output_index] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q   <= '0;
      state_q <= S_IDLE;
      ptr_q   <= '0;
      dv_q    <= 1'b0;
      dd_q    <= '0;
      di_q    <= '0;
      rd_q    <= '0;
      rv_q    <= 1'b0;
      rm_q    <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      state_q <= state_d;
      ptr_q   <= ptr_d;
      dv_q    <= dv_d;
      dd_q    <= dd_d;
      di_q    <= di_d;
      rd_q    <= rd_d;
      rv_q    <= read_enable;
      rm_q    <= rm_d;
    end
  end

  assign read_data      = rd_q;
  assign read_valid     = rv_q;
  assign read_miss      = rm_q;
  assign dmp.dump_valid = dv_q;
  assign dmp.dump_data  = dd_q;
  assign dmp.dump_index = di_q;
  assign dump_busy      = (state_q != S_IDLE);
  assign dump_done      = (state_q == S_DONE);

endmodule

// File: tb/tb_output_register_file.sv
// Scoreboard bench for output_register_file: read and dump beats
// are predicted from a bank model and checked as the DUT emits them.
module tb_output_register_file;

  logic       clk;
  logic       rst_n;
  logic       write_enable;
  logic       read_enable;
  logic [4:0] output_index;
  logic [7:0] data_in;
  logic [7:0] read_data;
  logic       read_valid;
  logic       read_miss;
  logic       clear_all;
  logic       dump_start;
  logic       dump_busy;
  logic       dump_done;

  output_register_file_if #(.DATA_W(8), .IDX_W(5)) dif ();

  output_register_file #(.DATA_W(8), .IDX_W(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .output_index (output_index),
    .data_in      (data_in),
    .read_data    (read_data),
    .read_valid   (read_valid),
    .read_miss    (read_miss),
    .clear_all    (clear_all),
    .dump_start   (dump_start),
    .dump_busy    (dump_busy),
    .dump_done    (dump_done),
    .dmp          (dif)
  );

  int checks = 0;
  int errors = 0;
  int beats  = 0;
  int dones  = 0;

  logic [7:0]  m_mem [32];
  logic [31:0] m_occ;
  logic [8:0]  rdq [$];
  logic [12:0] dq  [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (read_valid) begin
        if (rdq.size() == 0) begin
          chk("rd_extra", 1, 0);
        end else begin
          logic [8:0] e;
          e = rdq.pop_front();
          chk("rd_data", {24'd0, read_data}, {24'd0, e[7:0]});
          chk("rd_miss", {31'd0, read_miss}, {31'd0, e[8]});
        end
      end
      if (dif.dump_valid && dif.dump_ready) begin
        beats++;
        if (dq.size() == 0) begin
          chk("dump_extra", 1, 0);
        end else begin
          logic [12:0] e;
          e = dq.pop_front();
          chk("dump_idx", {27'd0, dif.dump_index}, {27'd0, e[12:8]});
          chk("dump_data", {24'd0, dif.dump_data}, {24'd0, e[7:0]});
        end
      end
      if (dump_done)
        dones++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input bit we, input bit re, input int idx,
                    input int d);
    logic [7:0] dv;
    dv = d[7:0];
    write_enable = we;
    read_enable  = re;
    output_index = idx[4:0];
    data_in      = dv;
    if (re) begin
      if (we)
        rdq.push_back({1'b0, dv});
      else if (m_occ[idx])
        rdq.push_back({1'b0, m_mem[idx]});
      else
        rdq.push_back({1'b1, 8'h00});
    end
`ifdef OUTREG_READ_CLEAR_EN
    if (re)
      m_occ[idx] = 1'b0;
`endif
    if (we) begin
      m_mem[idx] = dv;
      m_occ[idx] = 1'b1;
    end
    tick();
    write_enable = 1'b0;
    read_enable  = 1'b0;
  endtask

  task automatic clr();
    clear_all = 1'b1;
    m_occ = '0;
    tick();
    clear_all = 1'b0;
  endtask

  task automatic push_dump();
    for (int i = 0; i < 32; i++)
      if (m_occ[i])
        dq.push_back({i[4:0], m_mem[i]});
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!dump_done && n < 200) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, dump_done}, 1);
  endtask

  initial begin
    int n;
    int d0;
    int b0;
    rst_n        = 1'b0;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    output_index = '0;
    data_in      = '0;
    clear_all    = 1'b0;
    dump_start   = 1'b0;
    dif.dump_ready = 1'b0;
    m_occ = '0;
    for (int i = 0; i < 32; i++)
      m_mem[i] = 8'h00;

    #3;
    chk("rst_rd_data", {24'd0, read_data}, 0);
    chk("rst_rd_valid", {31'd0, read_valid}, 0);
    chk("rst_rd_miss", {31'd0, read_miss}, 0);
    chk("rst_dv", {31'd0, dif.dump_valid}, 0);
    chk("rst_dd", {24'd0, dif.dump_data}, 0);
    chk("rst_di", {27'd0, dif.dump_index}, 0);
    chk("rst_busy", {31'd0, dump_busy}, 0);
    chk("rst_done", {31'd0, dump_done}, 0);
    #9;
    rst_n = 1'b1;
    tick();

    op(0, 1, 3, 0);
    op(1, 0, 7, 8'h5A);
    op(0, 1, 7, 0);
    op(1, 1, 9, 8'h11);
    tick();

    // Two beats at the extremes of the bank.
    clr();
    op(1, 0, 0, 8'h01);
    op(1, 0, 31, 8'hFF);
    dif.dump_ready = 1'b1;
    push_dump();
    d0 = dones;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    wait_done("dump2_done");
    tick();
    chk("dump2_pulses", dones, d0 + 1);
    chk("dump2_busy", {31'd0, dump_busy}, 0);
    chk("dump2_q", dq.size(), 0);
`ifdef OUTREG_READ_CLEAR_EN
    m_occ = '0;
`endif

    // Empty bank latency.
    clr();
    b0 = beats;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    n = 0;
    while (!dump_done && n < 100) begin
      tick();
      n++;
    end
    chk("empty_lat", n, 32);
    chk("empty_beats", beats, b0);
    tick();
    chk("empty_busy", {31'd0, dump_busy}, 0);

    // Backpressure, snapshot and abort.
    clr();
    op(1, 0, 2, 8'h22);
    op(1, 0, 5, 8'h55);
    op(1, 0, 20, 8'hA0);
    dif.dump_ready = 1'b0;
    dq.push_back({5'd2, 8'h22});
    d0 = dones;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    n = 0;
    while (!dif.dump_valid && n < 100) begin
      tick();
      n++;
    end
    chk("bp_idx", {27'd0, dif.dump_index}, 2);
    chk("bp_data0", {24'd0, dif.dump_data}, 8'h22);
    op(1, 0, 2, 8'h99);
    for (int k = 0; k < 4; k++) begin
      chk("bp_hold", {24'd0, dif.dump_data}, 8'h22);
      tick();
    end
    chk("bp_valid", {31'd0, dif.dump_valid}, 1);
    dif.dump_ready = 1'b1;
    tick();
    dif.dump_ready = 1'b0;
`ifdef OUTREG_READ_CLEAR_EN
    m_occ[2] = 1'b0;
`endif
    n = 0;
    while (!dif.dump_valid && n < 100) begin
      tick();
      n++;
    end
    chk("ab_idx", {27'd0, dif.dump_index}, 5);
    chk("ab_data", {24'd0, dif.dump_data}, 8'h55);
    clr();
    chk("ab_valid", {31'd0, dif.dump_valid}, 0);
    chk("ab_busy", {31'd0, dump_busy}, 0);
    tick();
    tick();
    chk("ab_nodone", dones, d0);
    chk("ab_q", dq.size(), 0);

    // Read-clear behaviour, then a random mix.
    op(1, 0, 4, 8'h44);
    op(0, 1, 4, 0);
    op(0, 1, 4, 0);
    for (int k = 0; k < 60; k++)
      op($urandom_range(0, 1), $urandom_range(0, 1),
         $urandom_range(0, 31), $urandom_range(0, 255));
    tick();
    tick();
    chk("rd_q_empty", rdq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/output_register_file.md
Name: output_register_file

Overview:
- Storage and responder end of the OUTPUT / OUTPUT_READ instruction path. Holds computed results in a 2**IDX_W-entry bank.
- Takes write_enable / read_enable / output_index from the control unit and result data from the ALU.
- Returns registered read data with a valid/miss flag.
- A dump engine streams every occupied entry out over a valid/ready handshake to the board-level result sink.

Parameters:
DATA_W, 8, width of one stored result
IDX_W, 5, index width; DEPTH = 2**IDX_W entries (32)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
write_enable  in  1  store data_in at output_index this cycle
read_enable  in  1  read entry output_index
output_index  in  IDX_W  entry address for read and write
data_in  in  DATA_W  ALU result to store
read_data  out  DATA_W  registered read result
read_valid  out  1  one-cycle pulse, read_data valid
read_miss  out  1  qualifies read_valid: entry was never written / cleared
clear_all  in  1  synchronous clear of all occupancy bits, aborts dump
dump_start  in  1  begin streaming all occupied entries
dump_valid  out  1  dump_data/dump_index valid
dump_ready  in  1  sink accepts current dump beat
dump_data  out  DATA_W  streamed entry value
dump_index  out  IDX_W  streamed entry index
dump_busy  out  1  dump engine not IDLE
dump_done  out  1  one-cycle pulse, dump completed normally

Behaviour:
- Reset (rst_n low, async):
  - All entries = 0; occupancy bits = 0.
  - read_data = 0, read_valid = 0, read_miss = 0.
  - dump_valid = 0, dump_data = 0, dump_index = 0, dump_busy = 0, dump_done = 0; FSM = IDLE.
  - Reset asserted mid-dump abandons the dump; no dump_done.
- Write: write_enable high at a rising edge -> mem[output_index] = data_in, occupancy[output_index] = 1. Writes are always accepted, including during a dump.
- Read latency is 1 cycle. read_enable high in cycle N -> read_valid = 1 in cycle N+1 only.
  - Occupied entry: read_data = stored value, read_miss = 0.
  - Unoccupied entry: read_data = 0, read_miss = 1.
  - read_data holds its last value when read_valid = 0.
- Read and write to the same index in one cycle: write-first; read returns data_in with read_miss = 0. Read and write to different indices both proceed.
- clear_all: at the edge, all occupancy bits = 0 (data untouched).
  - A write in the same cycle wins for its index (occupied afterwards).
  - Any dump in progress returns to IDLE, dump_valid drops, no dump_done.
- Dump FSM: IDLE, SCAN, SEND, DONE.
  - IDLE: dump_start -> SCAN with ptr = 0. dump_start while busy is ignored.
  - SCAN, ptr occupied: latch dump_data = mem[ptr], dump_index = ptr, set dump_valid -> SEND.
  - SCAN, ptr not occupied: if ptr == DEPTH-1 -> DONE, else ptr+1 and stay in SCAN.
  - SEND: hold dump_valid and data stable until dump_ready. On the handshake edge dump_valid = 0; if ptr == DEPTH-1 -> DONE, else ptr+1 -> SCAN.
  - DONE: dump_done = 1 for one cycle -> IDLE.
  - dump_busy = 1 in SCAN, SEND and DONE.
- Timing: one SCAN cycle per entry. Empty bank, dump_start sampled at edge E -> dump_done high in the cycle after edge E+32.
- Writes during a dump:
  - Index below ptr: not emitted.
  - Index above ptr: emitted with the new value.
  - Entry currently in SEND: dump_data does not change (snapshot).
- Entries are always emitted in ascending index order.

Optional Feature:
OUTREG_READ_CLEAR_EN
- Defined: a read-port access clears the addressed entry's occupancy bit at the same edge (destructive read). A dump handshake clears occupancy[dump_index]. A write to the same index in the same cycle wins and the entry stays occupied with the new data.
- Undefined: reads and dumps never alter occupancy.

Test Plan:
- Reset, then read idx 3 -> next cycle read_valid = 1, read_miss = 1, read_data = 0x00.
- Write 0x5A to idx 7, read idx 7 next cycle -> read_valid = 1, read_data = 0x5A, read_miss = 0. Same-cycle write 0x11 + read idx 9 -> read_data = 0x11.
- Write idx 0 = 0x01, idx 31 = 0xFF, dump_start with dump_ready held 1 -> beats (0, 0x01) then (31, 0xFF), then dump_done pulse, dump_busy low.
- Empty bank, dump_start -> no dump_valid; dump_done in the cycle after the 32nd edge following the start.
- Dump with dump_ready = 0 for 5 cycles on beat idx 2 (0x22), write 0x99 to idx 2 meanwhile -> dump_data stays 0x22 until the handshake. Assert clear_all mid-dump -> dump_valid = 0, FSM IDLE, no dump_done.
- With OUTREG_READ_CLEAR_EN: write idx 4 = 0x44, read twice -> first read 0x44 with miss = 0, second read miss = 1 / data 0. Without the macro both reads return 0x44.
